// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: data-cache line writeback/refill and cache-op controller
module dcache_refill_ctrl #(
  parameter int CACHE_SHIFT = 12,
  localparam int TAG_W = 28 - CACHE_SHIFT,
  localparam int WS = CACHE_SHIFT - 10,
  localparam int WORDS = 1 << WS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic [2:0]       req_op_i,
  input  logic [7:0]       req_index_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic [TAG_W:0]   victim_tag_i,
  input  logic             victim_dirty_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       line_idx_o,
  output logic             grab_sram_r_o,
  output logic [7+WS:0]    sram_addr_o,
  input  logic [31:0]      sram_rdata_i,
  output logic             sram_we_o,
  output logic [31:0]      sram_wdata_o,
  output logic             tag_we_o,
  output logic [TAG_W:0]   tag_wdata_o,
  output logic             dirty_we_o,
  output logic             dirty_wdata_o,
  output logic             bus_avalid_o,
  output logic             bus_awrite_o,
  output logic [27:0]      bus_addr_o,
  input  logic             bus_aready_i,
  output logic             bus_wvalid_o,
  output logic [31:0]      bus_wdata_o,
  input  logic             bus_wready_i,
  input  logic             bus_rvalid_i,
  input  logic [31:0]      bus_rdata_i
);
  typedef enum logic [2:0] {IDLE, WB_A, WB_D, RF_A, RF_D, UPD, FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] idx_q;
  logic [TAG_W-1:0] tag_q, vtag_q;
  logic wb_q, rf_q;
  logic [WS:0] rd_cnt;
  logic [WS-1:0] wr_cnt, rf_cnt;
  logic rd_pend, buf_full;
  logic [31:0] buf_data;
  logic wb_need, rf_need, w_fire, rd_issue, rf_beat, wb_keep, rf_keep;
  logic upd, fill, inv;
  assign rf_need = req_op_i == 3'd1 || req_op_i == 3'd2;
  assign wb_need = victim_tag_i[TAG_W] && victim_dirty_i &&
                   (rf_need || req_op_i == 3'd5 ||
                    (req_op_i == 3'd3 && victim_tag_i[TAG_W-1:0] == req_tag_i));
  assign w_fire = state_q == WB_D && buf_full && bus_wready_i;
  // a read in flight already owns the buffer slot it will land in
  assign rd_issue = state_q == WB_D && rd_cnt != (WS+1)'(WORDS) && !rd_pend && (!buf_full || w_fire);
  assign rf_beat = state_q == RF_D && bus_rvalid_i;
  assign wb_keep = state_q == WB_D && state_d == WB_D;
  assign rf_keep = state_q == RF_D && state_d == RF_D;
  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = wb_need ? WB_A : rf_need ? RF_A : UPD;
      WB_A: if (bus_aready_i) state_d = WB_D;
      WB_D: if (w_fire && wr_cnt == WS'(WORDS - 1)) state_d = rf_q ? RF_A : UPD;
      RF_A: if (bus_aready_i) state_d = RF_D;
      RF_D: if (rf_beat && rf_cnt == WS'(WORDS - 1)) state_d = UPD;
      UPD:  state_d = FIN;
      default: state_d = IDLE;
    endcase
  end
  // state, request capture, writeback buffer and beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      idx_q <= '0;
      tag_q <= '0;
      vtag_q <= '0;
      wb_q <= 1'b0;
      rf_q <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      rf_cnt <= '0;
      rd_pend <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        op_q <= req_op_i;
        idx_q <= req_index_i;
        tag_q <= req_tag_i;
        vtag_q <= victim_tag_i[TAG_W-1:0];
        wb_q <= wb_need;
        rf_q <= rf_need;
      end
      rd_pend <= wb_keep && rd_issue;
      rd_cnt <= wb_keep ? rd_cnt + (WS+1)'(rd_issue) : '0;
      wr_cnt <= wb_keep ? wr_cnt + WS'(w_fire) : '0;
      buf_full <= wb_keep && (rd_pend || (buf_full && !w_fire));
      if (rd_pend) buf_data <= sram_rdata_i;
      rf_cnt <= rf_keep ? rf_cnt + WS'(rf_beat) : '0;
    end
  end
  assign upd = state_q == UPD;
  assign fill = op_q == 3'd1 || op_q == 3'd2;
  assign inv = op_q == 3'd4 || op_q == 3'd5;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == FIN;
  assign line_idx_o = idx_q;
  assign grab_sram_r_o = state_q == WB_D;
  assign sram_we_o = rf_beat;
  assign sram_addr_o = grab_sram_r_o ? {idx_q, rd_cnt[WS-1:0]} : rf_beat ? {idx_q, rf_cnt} : '0;
  assign sram_wdata_o = rf_beat ? bus_rdata_i : '0;
  assign bus_avalid_o = state_q == WB_A || state_q == RF_A;
  assign bus_awrite_o = state_q == WB_A;
  assign bus_addr_o = state_q == WB_A ? {vtag_q, idx_q, (WS+2)'(0)} :
                      state_q == RF_A ? {tag_q, idx_q, (WS+2)'(0)} : '0;
  assign bus_wvalid_o = grab_sram_r_o && buf_full;
  assign bus_wdata_o = bus_wvalid_o ? buf_data : '0;
  assign tag_we_o = upd && (fill || inv);
  assign tag_wdata_o = !tag_we_o ? '0 : fill ? {1'b1, tag_q} : {1'b0, vtag_q};
  assign dirty_we_o = upd && (fill || inv || (op_q == 3'd3 && wb_q));
  assign dirty_wdata_o = dirty_we_o && op_q == 3'd2;
endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// tb_dcache_refill_ctrl: directed self-checking bench for dcache_refill_ctrl
module tb_dcache_refill_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic req_valid_i;
  logic [2:0] req_op_i;
  logic [7:0] req_index_i;
  logic [15:0] req_tag_i;
  logic [16:0] victim_tag_i;
  logic victim_dirty_i;
  logic busy_o, done_o, grab_sram_r_o, sram_we_o, tag_we_o, dirty_we_o, dirty_wdata_o;
  logic [7:0] line_idx_o;
  logic [9:0] sram_addr_o;
  logic [31:0] sram_rdata_i, sram_wdata_o, bus_wdata_o, bus_rdata_i;
  logic [16:0] tag_wdata_o;
  logic bus_avalid_o, bus_awrite_o, bus_aready_i, bus_wvalid_o, bus_wready_i, bus_rvalid_i;
  logic [27:0] bus_addr_o;
  logic [9:0] prev_addr;
  logic any_out;
  int checks = 0, failures = 0, done_cnt = 0, act_cnt = 0;
  logic [31:0] sw_a[$], sw_d[$], wb_d[$], tg[$], dt[$];
  bit wpat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  dcache_refill_ctrl #(.CACHE_SHIFT(12)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
    .req_index_i(req_index_i), .req_tag_i(req_tag_i), .victim_tag_i(victim_tag_i),
    .victim_dirty_i(victim_dirty_i), .busy_o(busy_o), .done_o(done_o),
    .line_idx_o(line_idx_o), .grab_sram_r_o(grab_sram_r_o), .sram_addr_o(sram_addr_o),
    .sram_rdata_i(sram_rdata_i), .sram_we_o(sram_we_o), .sram_wdata_o(sram_wdata_o),
    .tag_we_o(tag_we_o), .tag_wdata_o(tag_wdata_o), .dirty_we_o(dirty_we_o),
    .dirty_wdata_o(dirty_wdata_o), .bus_avalid_o(bus_avalid_o), .bus_awrite_o(bus_awrite_o),
    .bus_addr_o(bus_addr_o), .bus_aready_i(bus_aready_i), .bus_wvalid_o(bus_wvalid_o),
    .bus_wdata_o(bus_wdata_o), .bus_wready_i(bus_wready_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // data RAM model: word at address a holds D000_0000 + a, one-cycle read latency
  always @(posedge clk) prev_addr <= sram_addr_o;
  assign sram_rdata_i = 32'hD000_0000 + {22'd0, prev_addr};

  assign any_out = |{busy_o, done_o, line_idx_o, grab_sram_r_o, sram_addr_o, sram_we_o,
                     sram_wdata_o, tag_we_o, tag_wdata_o, dirty_we_o, dirty_wdata_o,
                     bus_avalid_o, bus_awrite_o, bus_addr_o, bus_wvalid_o, bus_wdata_o};

  // record every RAM write, write beat and completion seen mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (sram_we_o) begin
        sw_a.push_back(32'(sram_addr_o));
        sw_d.push_back(sram_wdata_o);
      end
      if (bus_wvalid_o && bus_wready_i) wb_d.push_back(bus_wdata_o);
      if (tag_we_o) tg.push_back(32'(tag_wdata_o));
      if (dirty_we_o) dt.push_back(32'(dirty_wdata_o));
      if (done_o) done_cnt++;
      if (bus_avalid_o || grab_sram_r_o || sram_we_o || tag_we_o || dirty_we_o || bus_wvalid_o) act_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] q[$], input int n,
                         input logic [31:0] base, input logic [31:0] step);
    chk({tag, "_n"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < q.size() && i < n; i++) chk(tag, q[i], base + step * 32'(i));
  endtask

  task automatic clear();
    sw_a.delete(); sw_d.delete(); wb_d.delete(); tg.delete(); dt.delete();
    done_cnt = 0;
    act_cnt = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] idx, input logic [15:0] tag,
                       input logic [16:0] vic, input logic dirty);
    @(posedge clk); #1;
    req_valid_i = 1'b1; req_op_i = op; req_index_i = idx;
    req_tag_i = tag; victim_tag_i = vic; victim_dirty_i = dirty;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wb_phase(input logic [27:0] a, input bit pat);
    int n = 0;
    while (!(bus_avalid_o && bus_awrite_o) && n < 50) begin @(negedge clk); n++; end
    chk("wb_avalid", 32'(bus_avalid_o && bus_awrite_o), 32'd1);
    chk("wb_addr", 32'(bus_addr_o), 32'(a));
    n = 0;
    do begin
      @(posedge clk); #1;
      bus_wready_i = (pat && n < 7) ? wpat[n] : 1'b1;
      n++;
      @(negedge clk);
    end while (grab_sram_r_o && n < 80);
    bus_wready_i = 1'b0;
    chk("wb_exit", 32'(grab_sram_r_o), 32'd0);
  endtask

  task automatic rf_phase(input logic [27:0] a, input logic [31:0] base, input int nb);
    int n = 0;
    while (!(bus_avalid_o && !bus_awrite_o) && n < 50) begin @(negedge clk); n++; end
    chk("rf_avalid", 32'(bus_avalid_o && !bus_awrite_o), 32'd1);
    chk("rf_addr", 32'(bus_addr_o), 32'(a));
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      bus_rvalid_i = 1'b1;
      bus_rdata_i = base + 32'(i);
      @(posedge clk); #1;
    end
    bus_rvalid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 50) begin @(negedge clk); n++; end
    chk("done", 32'(done_o), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 32'd0);
    chk("idle", 32'(busy_o), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_index_i = '0; req_tag_i = '0;
    victim_tag_i = '0; victim_dirty_i = 1'b0; bus_aready_i = 1'b1; bus_wready_i = 1'b0;
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_outs", 32'(any_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // READ into invalid victim: plain refill
    clear();
    issue(3'd1, 8'h12, 16'h0ABC, 17'h01234, 1'b1);
    rf_phase(28'h0ABC120, 32'hA, 4);
    wait_done();
    chk_seq("rd_sram_a", sw_a, 4, 32'h48, 32'd1);
    chk_seq("rd_sram_d", sw_d, 4, 32'hA, 32'd1);
    chk_seq("rd_tag", tg, 1, 32'h10ABC, 32'd0);
    chk_seq("rd_dirty", dt, 1, 32'd0, 32'd0);
    chk("rd_no_wb", 32'(wb_d.size()), 32'd0);

    // WRITE with dirty victim: writeback then refill
    clear();
    issue(3'd2, 8'h12, 16'h0ABC, 17'h10055, 1'b1);
    wb_phase(28'h0055120, 1'b0);
    rf_phase(28'h0ABC120, 32'h100, 4);
    wait_done();
    chk_seq("wr_wb", wb_d, 4, 32'hD000_0048, 32'd1);
    chk_seq("wr_sram_a", sw_a, 4, 32'h48, 32'd1);
    chk_seq("wr_tag", tg, 1, 32'h10ABC, 32'd0);
    chk_seq("wr_dirty", dt, 1, 32'd1, 32'd0);

    // INVALID_WB with stalling wready
    clear();
    issue(3'd5, 8'h21, 16'h0ABC, 17'h10055, 1'b1);
    wb_phase(28'h0055210, 1'b1);
    wait_done();
    chk_seq("iwb_wb", wb_d, 4, 32'hD000_0084, 32'd1);
    chk_seq("iwb_tag", tg, 1, 32'h00055, 32'd0);
    chk_seq("iwb_dirty", dt, 1, 32'd0, 32'd0);
    chk("iwb_no_sram", 32'(sw_a.size()), 32'd0);

    // HIT_WB with tag mismatch: minimum latency, no activity
    clear();
    issue(3'd3, 8'h30, 16'h0ABC, 17'h10055, 1'b1);
    @(negedge clk);
    chk("hwb_upd", {30'd0, busy_o, done_o}, 32'd2);
    chk("hwb_idx", 32'(line_idx_o), 32'h30);
    @(negedge clk);
    chk("hwb_done", 32'(done_o), 32'd1);
    @(negedge clk);
    chk("hwb_idle", 32'(busy_o), 32'd0);
    chk("hwb_act", 32'(act_cnt), 32'd0);

    // HIT_WB with tag match: writeback, then clean
    clear();
    issue(3'd3, 8'h30, 16'h0055, 17'h10055, 1'b1);
    wb_phase(28'h0055300, 1'b0);
    wait_done();
    chk_seq("hwbm_wb", wb_d, 4, 32'hD000_00C0, 32'd1);
    chk_seq("hwbm_dirty", dt, 1, 32'd0, 32'd0);
    chk("hwbm_no_tag", 32'(tg.size()), 32'd0);

    // INVALID
    clear();
    issue(3'd4, 8'h07, 16'h0ABC, 17'h10077, 1'b0);
    wait_done();
    chk_seq("inv_tag", tg, 1, 32'h00077, 32'd0);
    chk_seq("inv_dirty", dt, 1, 32'd0, 32'd0);

    // reset in the middle of a refill, then a normal READ
    clear();
    issue(3'd1, 8'h05, 16'h0ABC, 17'h00000, 1'b0);
    rf_phase(28'h0ABC050, 32'h50, 2);
    chk("mid_beats", 32'(sw_a.size()), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_outs", 32'(any_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear();
    issue(3'd1, 8'h05, 16'h0ABC, 17'h00000, 1'b0);
    rf_phase(28'h0ABC050, 32'h50, 4);
    wait_done();
    chk_seq("post_sram_a", sw_a, 4, 32'h14, 32'd1);
    chk_seq("post_sram_d", sw_d, 4, 32'h50, 32'd1);
    chk_seq("post_tag", tg, 1, 32'h10ABC, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_refill_ctrl.md
DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

Interface
REQ-001 SHALL have parameter CACHE_SHIFT, default 12, giving cache size as 2^CACHE_SHIFT bytes; legal values 12-14.
REQ-002 SHALL derive TAG_W = 28-CACHE_SHIFT, WS = CACHE_SHIFT-10 and WORDS = 2^WS (words per line); there SHALL be 256 lines.
REQ-003 clk  in  1  clock; single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  1  M2 miss or cache-op request; sampled only in IDLE.
REQ-006 req_op_i  in  3  1 READ, 2 WRITE, 3 HIT_WB, 4 INVALID, 5 INVALID_WB; any other value is NOP.
REQ-007 req_index_i  in  8  line index.
REQ-008 req_tag_i  in  TAG_W  requested tag, paddr[27:CACHE_SHIFT].
REQ-009 victim_tag_i  in  TAG_W+1  {valid, tag} currently stored at index.
REQ-010 victim_dirty_i  in  1  dirty bit currently stored at index.
REQ-011 busy_o  out  1  high whenever state is not IDLE.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 line_idx_o  out  8  captured index; write address for tag and dirty RAMs.
REQ-014 grab_sram_r_o  out  1  controller owns the data-RAM read port.
REQ-015 sram_addr_o  out  8+WS  {line_idx, word}; read address while grabbing, write address while sram_we_o.
REQ-016 sram_rdata_i  in  32  read data for the address presented in the previous cycle.
REQ-017 sram_we_o  out  1  data-RAM write enable.
REQ-018 sram_wdata_o  out  32  data-RAM write data.
REQ-019 tag_we_o  out  1  tag RAM write enable.
REQ-020 tag_wdata_o  out  TAG_W+1  {valid, tag} to write.
REQ-021 dirty_we_o  out  1  dirty RAM write enable.
REQ-022 dirty_wdata_o  out  1  dirty value to write.
REQ-023 bus_avalid_o  out  1  address-phase valid.
REQ-024 bus_awrite_o  out  1  1 = line write, 0 = line read.
REQ-025 bus_addr_o  out  28  line-aligned physical address.
REQ-026 bus_aready_i  in  1  address accepted.
REQ-027 bus_wvalid_o  out  1  write beat valid.
REQ-028 bus_wdata_o  out  32  write beat data.
REQ-029 bus_wready_i  in  1  write beat accepted.
REQ-030 bus_rvalid_i  in  1  refill beat valid; no backpressure.
REQ-031 bus_rdata_i  in  32  refill beat data.

Function
REQ-032 States SHALL be IDLE, WB_A, WB_D, RF_A, RF_D, UPD, FIN.
REQ-033 Accept: in IDLE with req_valid_i high, op, index, req_tag, victim and dirty SHALL be captured; requests outside IDLE are ignored.
REQ-034 Writeback is needed when victim valid and dirty, and either op is 1, 2 or 5, or op is 3 with victim tag equal to req_tag. Refill is needed when op is 1 or 2.
REQ-035 Next state from IDLE: WB_A if writeback is needed; otherwise RF_A if refill is needed; otherwise UPD.
REQ-036 WB_A: drive avalid=1, awrite=1, addr={victim tag, index, (WS+2) zeros}. Hold address stable until aready, then go to WB_D.
REQ-037 WB_D: grab_sram_r_o=1. Read words 0..WORDS-1 in order into a 1-entry buffer; wvalid=1 while the buffer is full. Issue the next read only if the buffer is empty or drains in the same cycle. After the WORDS-th w handshake, go to RF_A if refill is needed, else UPD.
REQ-038 RF_A: drive avalid=1, awrite=0, addr={req_tag, index, zeros}. On aready, go to RF_D.
REQ-039 RF_D: on each rvalid, sram_we_o=1, addr={index, cnt}, wdata=rdata, cnt+1. After WORDS beats, go to UPD. Beats outside RF_D are ignored.
REQ-040 UPD, one cycle:
- ops 1/2: tag {1, req_tag}; dirty = (op==2).
- op 3: write dirty=0 only if a writeback occurred.
- ops 4/5: tag {0, victim tag}; dirty=0.
- NOP: no writes.
Then go to FIN.
REQ-041 FIN: done_o=1 for one cycle, then IDLE. Counters SHALL be zero on exiting any state.
REQ-042 Minimum latency: accept at cycle T gives UPD at T+1 and done_o at T+2. Every write-enable, avalid and wvalid output SHALL be 0 outside its own state.

Reset
REQ-043 On rst, the controller SHALL enter IDLE next cycle and clear counters and the buffer. All outputs SHALL be 0, including mid-transfer; the in-flight bus transfer is abandoned.

Verification
REQ-044 READ, index 0x12, victim {0, x}, CACHE_SHIFT=12, aready immediate, beats A..D -> sram writes at 0x48..0x4B, then tag {1, req_tag}, dirty 0, done_o once.
REQ-045 WRITE, victim {1, 0x0055}, dirty -> write address 0x0055120 with 4 words in order, then read at {req_tag, 0x12, 0}, then dirty_wdata 1.
REQ-046 Writeback with bus_wready pattern 1,0,0,1,0,1,1 -> exactly 4 beats, in order, none duplicated or dropped.
REQ-047 HIT_WB with tag mismatch -> no bus or RAM activity, done at T+2. INVALID -> tag_wdata {0, victim tag}.
REQ-048 rst asserted in RF_D after 2 beats -> IDLE and all outputs 0 next cycle; the next READ completes normally.
